// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state
// encoding, the default memory-stall timeout and a helper for sizing the
// wait counter.
package pipe_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_MEM_WAIT = 2'd1;
  localparam state_t ST_ERROR    = 2'd2;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int wait_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_timer.sv
// stall_timer: counts consecutive memory-stall cycles spent in MEM_WAIT and
// flags when the next stalled edge would exhaust the tolerated budget.
// The counter saturates rather than wrapping so a held 'run' can never make
// the timeout compare fire a second time after an overflow.
module stall_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CW = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] wait_cnt;

  // Clear wins, then a fresh stall loads 1, otherwise count up while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= CNT_ONE;
    end else if (run && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

  // The budget is spent when the current stall cycle is the last one allowed.
  always_comb begin
    expired = (wait_cnt == CNT_LAST);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: freeze/flush controller for a 5-stage pipeline with a memory
// stall watchdog. Freeze and flush decode is purely combinational so a stall
// costs no extra latency; the FSM only tracks how long a stall has lasted
// and latches a sticky error once the timeout budget is exhausted.
// Optional feature macro: PIPE_PERF_CNT_EN enables the saturating stall and
// flush performance counters; without it both counter ports are tied to 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        if_freeze,
  output logic        if_flush,
  output logic        id_flush,
  output logic        pipe_freeze,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  state_t state;
  state_t state_nxt;
  logic   mem_stall;
  logic   timer_start;
  logic   timer_run;
  logic   timer_clear;
  logic   timer_expired;

  stall_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_stall_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .run    (timer_run),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  // Next-state logic and timer control; ERROR is only left through reset.
  always_comb begin
    mem_stall   = mem_req & ~mem_ready;
    state_nxt   = state;
    timer_start = 1'b0;
    timer_run   = 1'b0;
    timer_clear = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          state_nxt   = ST_MEM_WAIT;
          timer_start = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_nxt   = ST_RUN;
          timer_clear = 1'b1;
        end else if (timer_expired) begin
          state_nxt   = ST_ERROR;
          timer_clear = 1'b1;
        end else begin
          timer_run   = 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_ERROR;
        timer_clear = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky timeout flag, raised on the same edge that enters ERROR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_timeout <= 1'b0;
    end else if (state_nxt == ST_ERROR) begin
      mem_timeout <= 1'b1;
    end
  end

  // Output decode: freeze beats branch, branch beats hazard; ERROR freezes all.
  always_comb begin
    if (state == ST_ERROR) begin
      pipe_freeze = 1'b1;
      if_freeze   = 1'b1;
      if_flush    = 1'b0;
      id_flush    = 1'b0;
    end else begin
      pipe_freeze = mem_stall;
      if_freeze   = mem_stall | (hazard & ~branch_taken);
      if_flush    = branch_taken & ~mem_stall;
      id_flush    = ~mem_stall & (branch_taken | hazard);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating count of cycles with the front end frozen, excluding ERROR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (if_freeze && (state != ST_ERROR) && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  // Saturating count of cycles in which the IF stage is flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_events <= '0;
    end else if (if_flush && (flush_events != 32'hFFFF_FFFF)) begin
      flush_events <= flush_events + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
